// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser and debounce FSM with settle counter,
// producing a clean level, rise/fall pulses and hold-to-auto-repeat pulses.
module button_conditioner #(
    parameter int             CH         = 5,
    parameter int             CW         = 16,
    parameter logic [CW-1:0]  N          = 16'hffff,
    parameter int             SYNC       = 2,
    parameter bit             RPT_EN     = 1'b1,
    parameter int             TDW        = 24,
    parameter logic [TDW-1:0] TICK_DIV   = 24'd1_000_000,
    parameter logic [7:0]     HOLD_TICKS = 8'd50,
    parameter logic [7:0]     REP_TICKS  = 8'd10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] i,
    output logic [CH-1:0] y,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] rpt
);
    typedef enum logic [1:0] {
        LOW    = 2'b00,
        LOW_P  = 2'b01,
        HIGH   = 2'b11,
        HIGH_P = 2'b10
    } state_t;

    logic [SYNC-1:0][CH-1:0] sync_q, sync_d;
    state_t                  state_q [CH];
    state_t                  state_d [CH];
    logic [CW-1:0]           c_q [CH];
    logic [CW-1:0]           c_d [CH];
    logic [7:0]              hc_q [CH];
    logic [7:0]              hc_d [CH];
    logic [CH-1:0]           rise_q, rise_d, fall_q, fall_d, rpt_q, rpt_d, ph_q, ph_d;
    logic [CH-1:0]           s, y_cur, y_nxt, adv, wrap;
    logic [TDW-1:0]          div_q, div_d;
    logic                    tick_q, tick_d;

    always_comb begin
        sync_d = {sync_q[SYNC-2:0], i};
        s      = sync_q[SYNC-1];
        tick_d = (div_q == TICK_DIV - 1'b1);
        div_d  = tick_d ? '0 : div_q + 1'b1;
        for (int k = 0; k < CH; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                LOW:     state_d[k] = s[k] ? LOW_P : LOW;
                LOW_P:   state_d[k] = !s[k] ? LOW : (c_q[k] == N) ? HIGH : LOW_P;
                HIGH:    state_d[k] = s[k] ? HIGH : HIGH_P;
                default: state_d[k] = s[k] ? HIGH : (c_q[k] == N) ? LOW : HIGH_P;
            endcase
            y_cur[k]  = state_q[k][1];
            y_nxt[k]  = state_d[k][1];
            c_d[k]    = (^state_q[k] && state_d[k] == state_q[k]) ? c_q[k] + 1'b1 : '0;
            rise_d[k] = y_nxt[k] & ~y_cur[k];
            fall_d[k] = ~y_nxt[k] & y_cur[k];
            // Ticks count only while held and settled; the rise cycle itself restarts the hold.
            adv[k]    = tick_q & y_cur[k] & y_nxt[k] & ~rise_q[k];
            wrap[k]   = adv[k] && (hc_q[k] + 8'd1 == (ph_q[k] ? REP_TICKS : HOLD_TICKS));
            rpt_d[k]  = rise_d[k] | (RPT_EN & wrap[k]);
            hc_d[k]   = (!y_nxt[k] || !y_cur[k] || wrap[k]) ? 8'd0 : adv[k] ? hc_q[k] + 8'd1 : hc_q[k];
            ph_d[k]   = (!y_nxt[k] || !y_cur[k]) ? 1'b0 : wrap[k] | ph_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
            rise_q <= '0;
            fall_q <= '0;
            rpt_q  <= '0;
            ph_q   <= '0;
            for (int k = 0; k < CH; k++) begin
                state_q[k] <= LOW;
                c_q[k]     <= '0;
                hc_q[k]    <= '0;
            end
        end else begin
            sync_q <= sync_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            rpt_q  <= rpt_d;
            ph_q   <= ph_d;
            for (int k = 0; k < CH; k++) begin
                state_q[k] <= state_d[k];
                c_q[k]     <= c_d[k];
                hc_q[k]    <= hc_d[k];
            end
        end
    end

    assign y    = y_cur;
    assign rise = rise_q;
    assign fall = fall_q;
    assign rpt  = rpt_q;
endmodule
